nixie_seg_reader: RTL and testbench
===================================

// Module: nixie_seg_reader
// PURPOSE
//  Reader side of the 7-segment digit interface. Samples an external 7-bit segment bus.
//  Waits for the pattern to settle, then decodes it back to a 4-bit digit.
//  Delivers each settled digit once over a valid/ready port.
//  Used for display loopback checking and for reading segment-encoded sources.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical synced samples before accept (>=1)
//  SYNC_STAGES    2  input synchroniser depth (>=2)
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  asynchronous, active-high reset
//  seg_in     in   7  async segment bus {g,f,e,d,c,b,a}, active-high
//  out_valid  out  1  holding register holds a digit event
//  out_ready  in   1  consumer accepts when out_valid&out_ready
//  out_digit  out  4  decoded value 0x0-0xF
//  out_err    out  1  event was an illegal (non-table) pattern; out_digit=4'hF
//  ovf        out  1  sticky: event dropped because holding reg full
//  ovf_clr    in   1  synchronous clear of ovf (set wins if same cycle)
//  state_o    out  2  current FSM state (debug)
// BEHAVIOUR
//  Reset: out_valid=0, out_digit=0, out_err=0, ovf=0, sync regs=7'h00, cnt=0, state=SETTLE.
//  Sync: seg_in passes through SYNC_STAGES flops -> seg_s. cnt compares seg_s with seg_q (prev sample).
//  Table: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; A=77 b=7C C=39 d=5E E=79 F=71.
//  7'h00 = blank: valid "no digit" pattern, never produces an event.
//  FSM: SETTLE, LOCKED, BLANK.
//   SETTLE: seg_s!=seg_q -> cnt=0. Else cnt++, saturating at STABLE_CYCLES-1.
//    Reaching STABLE_CYCLES-1 with blank pattern -> BLANK, no event.
//    Reaching STABLE_CYCLES-1 otherwise -> LOCKED and emit one event.
//   LOCKED/BLANK: any seg_s!=seg_q -> SETTLE, cnt=0. Otherwise hold; no repeat events.
//  Latency: seg_in constant from cycle 0 -> out_valid high at cycle SYNC_STAGES+STABLE_CYCLES.
//   Default: cycle 6.
//  Event: loads out_digit/out_err and sets out_valid on the next edge.
//  Handshake: out_valid stays high, data stable, until out_valid&out_ready.
//  Same-cycle accept + new event: the new event loads. No bubble, no ovf.
//  Event while out_valid=1 and no accept: event dropped, ovf<=1, held data unchanged.
//  Glitch shorter than STABLE_CYCLES: returns to SETTLE, no event.
//   Re-settling on the same pattern emits a fresh event; the glitch marks a new display.
//  Reset mid-settle or mid-handshake: all state cleared immediately (async); pending event lost.
// CONFIGURATION
//  NIXIE_HEX_EN defined: A-F patterns decode to 0xA-0xF, out_err=0.
//  NIXIE_HEX_EN undefined: A-F patterns are illegal (out_err=1, out_digit=4'hF).
//   Digits 0-9 and blank are unaffected.
// STRUCTURE
//  nixie_pkg: SEG_0..SEG_F and SEG_BLANK 7-bit localparams; typedef enum logic[1:0]
//   {ST_SETTLE, ST_LOCKED, ST_BLANK} nixie_rd_state_t.
//  Sub-module nixie_seg_lut: combinational seg[6:0] -> {err, digit[3:0], blank}.
//   Honours NIXIE_HEX_EN.
//  Top holds the synchroniser, stability counter, FSM, holding register and ovf flag.
// TESTING
//  1. Reset, seg_in=7'h5B held, out_ready=1 -> single out_valid pulse at cycle 6, digit=2, err=0.
//  2. seg_in=7'h06 with out_ready=0 -> out_valid holds digit=1.
//     Then seg_in=7'h4F -> ovf=1, digit stays 1. Pulse ovf_clr -> ovf=0.
//  3. seg_in 7'h7F, then 7'h3F for 2 cycles, then 7'h7F:
//     one event digit=8, then (no event for the glitch) a second event digit=8.
//  4. seg_in=7'h00 for 20 cycles -> no out_valid, state_o=BLANK.
//     seg_in=7'h2A -> err=1, digit=F.
//  5. seg_in=7'h77: with NIXIE_HEX_EN -> digit=A, err=0; without it -> err=1, digit=F.
//  6. Assert rst during SETTLE and while out_valid=1 -> outputs 0 same cycle.
//     Re-settle after release -> event at cycle 6 after release.

Source files
------------

// File: rtl/nixie_pkg.sv
// Shared constants and FSM state type for the 7-segment digit reader.
// Segment codes are {g,f,e,d,c,b,a}, active-high.
package nixie_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_LOCKED = 2'd1,
        ST_BLANK  = 2'd2
    } nixie_rd_state_t;

endpackage

// File: rtl/nixie_seg_reader_if.sv
// Valid/ready digit-event port of the segment reader.
// The reader drives the master side, the consumer the slave side.
interface nixie_seg_reader_if;

    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_digit;
    logic       out_err;

    modport master (output out_valid, output out_digit, output out_err, input out_ready);
    modport slave  (input out_valid, input out_digit, input out_err, output out_ready);

endinterface

// File: rtl/nixie_seg_lut.sv
// Combinational 7-segment pattern to digit decoder.
// Macro NIXIE_HEX_EN: when defined, A-F patterns decode as hex digits; otherwise they are illegal.
module nixie_seg_lut
    import nixie_pkg::*;
(
    input  logic [6:0] seg,
    output logic       err,
    output logic [3:0] digit,
    output logic       blank
);

    // Anything not in the table, including A-F in decimal-only builds, reports err with digit F.
    always_comb begin
        err   = 1'b0;
        digit = 4'h0;
        blank = 1'b0;
        case (seg)
            SEG_BLANK: blank = 1'b1;
            SEG_0:     digit = 4'h0;
            SEG_1:     digit = 4'h1;
            SEG_2:     digit = 4'h2;
            SEG_3:     digit = 4'h3;
            SEG_4:     digit = 4'h4;
            SEG_5:     digit = 4'h5;
            SEG_6:     digit = 4'h6;
            SEG_7:     digit = 4'h7;
            SEG_8:     digit = 4'h8;
            SEG_9:     digit = 4'h9;
`ifdef NIXIE_HEX_EN
            SEG_A:     digit = 4'hA;
            SEG_B:     digit = 4'hB;
            SEG_C:     digit = 4'hC;
            SEG_D:     digit = 4'hD;
            SEG_E:     digit = 4'hE;
            SEG_F:     digit = 4'hF;
`endif
            default: begin
                err   = 1'b1;
                digit = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/nixie_seg_reader.sv
// Samples an async 7-segment bus, waits for it to settle and delivers each settled digit once.
// Hex decoding of A-F is enabled by the NIXIE_HEX_EN macro (see nixie_seg_lut).
module nixie_seg_reader
    import nixie_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                seg_in,
    nixie_seg_reader_if.master        out_if,
    output logic                      ovf,
    input  logic                      ovf_clr,
    output logic [1:0]                state_o
);

    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][6:0] sync_q;
    logic [6:0]                  seg_s;
    logic [6:0]                  seg_q;
    logic [CW-1:0]               cnt, cnt_n;
    nixie_rd_state_t             state, state_n;
    logic                        emit;
    logic                        lut_err, lut_blank;
    logic [3:0]                  lut_digit;

    assign seg_s   = sync_q[SYNC_STAGES-1];
    assign state_o = state;

    nixie_seg_lut u_lut (
        .seg   (seg_s),
        .err   (lut_err),
        .digit (lut_digit),
        .blank (lut_blank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            seg_q  <= '0;
            cnt    <= '0;
            state  <= ST_SETTLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], seg_in};
            seg_q  <= seg_s;
            cnt    <= cnt_n;
            state  <= state_n;
        end
    end

    // The event fires on the edge where the count reaches its limit, so the FSM and holding register move together.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        emit    = 1'b0;
        case (state)
            ST_SETTLE: begin
                if (seg_s != seg_q) begin
                    cnt_n = '0;
                end else begin
                    if (cnt != CNT_MAX) cnt_n = cnt + CW'(1);
                    if (cnt_n == CNT_MAX) begin
                        if (lut_blank) begin
                            state_n = ST_BLANK;
                        end else begin
                            state_n = ST_LOCKED;
                            emit    = 1'b1;
                        end
                    end
                end
            end
            default: begin
                if (seg_s != seg_q) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_if.out_valid <= 1'b0;
            out_if.out_digit <= 4'h0;
            out_if.out_err   <= 1'b0;
            ovf              <= 1'b0;
        end else begin
            if (emit && (!out_if.out_valid || out_if.out_ready)) begin
                out_if.out_valid <= 1'b1;
                out_if.out_digit <= lut_digit;
                out_if.out_err   <= lut_err;
            end else if (out_if.out_valid && out_if.out_ready) begin
                out_if.out_valid <= 1'b0;
            end
            if (emit && out_if.out_valid && !out_if.out_ready) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nixie_seg_reader.sv
// Directed plus randomized bench for nixie_seg_reader, checked against a run-length reference model.
// Honours NIXIE_HEX_EN for the expected decode of A-F patterns.
module tb_nixie_seg_reader;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic       ovf_clr = 1'b0;
    logic       ovf;
    logic [1:0] state_o;

    int vectors = 0;
    int miscompares = 0;

    nixie_seg_reader_if bus ();

    nixie_seg_reader #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg_in  (seg_in),
        .out_if  (bus),
        .ovf     (ovf),
        .ovf_clr (ovf_clr),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    logic [6:0] segTab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: an event fires when the synchronised sample has been identical for STABLE samples.
    logic [6:0] dl [$];
    int         runLen;
    logic       mValid, mErr, mOvf;
    logic [3:0] mDigit;
    logic [1:0] mState;

    function automatic void decode(input logic [6:0] s, output logic [3:0] d, output logic e);
        d = 4'hF;
        e = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (segTab[i] == s) begin
`ifdef NIXIE_HEX_EN
                d = 4'(i);
                e = 1'b0;
`else
                if (i < 10) begin
                    d = 4'(i);
                    e = 1'b0;
                end
`endif
            end
        end
    endfunction

    task automatic modelReset();
        dl.delete();
        for (int i = 0; i < SYNC + 1; i++) dl.push_back(7'h00);
        runLen = 1;
        mValid = 1'b0;
        mDigit = 4'h0;
        mErr   = 1'b0;
        mOvf   = 1'b0;
        mState = 2'd0;
    endtask

    task automatic modelStep(input logic [6:0] seg, input logic rdy, input logic clr);
        logic [6:0] cur;
        logic       emit, e;
        logic [3:0] d;
        dl.push_back(seg);
        cur = dl[1];
        if (cur == dl[0]) begin
            if (runLen <= STABLE) runLen++;
        end else begin
            runLen = 1;
        end
        void'(dl.pop_front());
        emit = (runLen == STABLE) && (cur != 7'h00);
        decode(cur, d, e);
        mState = (runLen >= STABLE) ? ((cur == 7'h00) ? 2'd2 : 2'd1) : 2'd0;
        if (emit && mValid && !rdy) mOvf = 1'b1;
        else if (clr) mOvf = 1'b0;
        if (emit && (!mValid || rdy)) begin
            mValid = 1'b1;
            mDigit = d;
            mErr   = e;
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
    endtask

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("out_valid", 8'(bus.out_valid), 8'(mValid));
        checkValue("out_digit", 8'(bus.out_digit), 8'(mDigit));
        checkValue("out_err",   8'(bus.out_err),   8'(mErr));
        checkValue("ovf",       8'(ovf),           8'(mOvf));
        checkValue("state_o",   8'(state_o),       8'(mState));
    endtask

    // One clock: drive inputs, advance the model on the edge, check on the falling edge.
    task automatic applyStimulus(input logic [6:0] seg, input logic rdy, input logic clr);
        seg_in        = seg;
        bus.out_ready = rdy;
        ovf_clr       = clr;
        @(posedge clk);
        modelStep(seg, rdy, clr);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset(input logic [6:0] seg);
        #2 rst = 1'b1;
        #1 modelReset();
        checkValue("rst_valid", 8'(bus.out_valid), 8'd0);
        checkValue("rst_digit", 8'(bus.out_digit), 8'd0);
        checkValue("rst_ovf",   8'(ovf),           8'd0);
        checkValue("rst_state", 8'(state_o),       8'd0);
        seg_in = seg;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int         evt;
    logic [6:0] rseg;
    int         hold;
    logic       rrdy, rclr;

    initial begin
        bus.out_ready = 1'b1;
        modelReset();
        $display("[TB] start");

        // Test 1: latency and single pulse with ready high
        doReset(7'h5B);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(7'h5B, 1'b1, 1'b0);
            checkValue("t1_latency", 8'(bus.out_valid), (i == 6) ? 8'd1 : 8'd0);
        end
        checkValue("t1_digit", 8'(bus.out_digit), 8'h2);
        checkValue("t1_err",   8'(bus.out_err),   8'h0);
        evt = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(7'h5B, 1'b1, 1'b0);
            evt += int'(bus.out_valid);
        end
        checkValue("t1_single_pulse", 8'(evt), 8'd0);

        // Test 2: hold with ready low, then overflow and clear
        for (int i = 0; i < 8; i++) applyStimulus(7'h06, 1'b0, 1'b0);
        checkValue("t2_hold_valid", 8'(bus.out_valid), 8'd1);
        checkValue("t2_hold_digit", 8'(bus.out_digit), 8'h1);
        for (int i = 0; i < 8; i++) applyStimulus(7'h4F, 1'b0, 1'b0);
        checkValue("t2_ovf",        8'(ovf),           8'd1);
        checkValue("t2_kept_digit", 8'(bus.out_digit), 8'h1);
        applyStimulus(7'h4F, 1'b0, 1'b1);
        checkValue("t2_ovf_clr", 8'(ovf), 8'd0);
        applyStimulus(7'h4F, 1'b1, 1'b0);

        // Test 3: glitch followed by the same digit yields a fresh event
        evt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(7'h7F, 1'b1, 1'b0);
            evt += int'(bus.out_valid);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(7'h3F, 1'b1, 1'b0);
            evt += int'(bus.out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(7'h7F, 1'b1, 1'b0);
            evt += int'(bus.out_valid);
        end
        checkValue("t3_events", 8'(evt), 8'd2);
        checkValue("t3_digit",  8'(bus.out_digit), 8'h8);

        // Test 4: blank never emits, illegal pattern reports error
        evt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(7'h00, 1'b1, 1'b0);
            if (i > 0) evt += int'(bus.out_valid);
        end
        checkValue("t4_blank_events", 8'(evt), 8'd0);
        checkValue("t4_blank_state",  8'(state_o), 8'd2);
        for (int i = 0; i < 6; i++) applyStimulus(7'h2A, 1'b0, 1'b0);
        checkValue("t4_ill_err",   8'(bus.out_err),   8'd1);
        checkValue("t4_ill_digit", 8'(bus.out_digit), 8'hF);
        applyStimulus(7'h2A, 1'b1, 1'b0);

        // Test 5: hex pattern
        for (int i = 0; i < 6; i++) applyStimulus(7'h77, 1'b0, 1'b0);
`ifdef NIXIE_HEX_EN
        checkValue("t5_hex_digit", 8'(bus.out_digit), 8'hA);
        checkValue("t5_hex_err",   8'(bus.out_err),   8'd0);
`else
        checkValue("t5_hex_digit", 8'(bus.out_digit), 8'hF);
        checkValue("t5_hex_err",   8'(bus.out_err),   8'd1);
`endif

        // Test 6: async reset while valid is held, then mid-settle, then re-settle latency
        doReset(7'h6D);
        for (int i = 0; i < 3; i++) applyStimulus(7'h6D, 1'b0, 1'b0);
        doReset(7'h66);
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(7'h66, 1'b0, 1'b0);
            checkValue("t6_latency", 8'(bus.out_valid), (i == 6) ? 8'd1 : 8'd0);
        end
        checkValue("t6_digit", 8'(bus.out_digit), 8'h4);

        // Randomized phase
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 19))
                16:      rseg = 7'h00;
                17, 18:  rseg = 7'($urandom_range(0, 127));
                19:      rseg = segTab[$urandom_range(0, 15)];
                default: rseg = segTab[$urandom_range(0, 15)];
            endcase
            hold = $urandom_range(1, 9);
            for (int k = 0; k < hold; k++) begin
                rrdy = ($urandom_range(0, 3) != 0);
                rclr = ($urandom_range(0, 15) == 0);
                applyStimulus(rseg, rrdy, rclr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
